// File: rtl/vga_snapshot_manager.sv
// vga_snapshot_manager: per-frame copy of CPU registers, instruction and data words into aux display memory
// Ports: clock_in/reset_n_in (async active-low); v_sync_in rising edge starts a copy, falling edge while busy aborts;
//   instr_base_in/data_base_in first read addresses; cpu_content_in selected by one-hot content_enable_out;
//   instruction/data_address_out issue reads answered READ_LATENCY cycles later on *_memory_in;
//   aux_wr_out/aux_waddress_out/aux_data_out write port; busy_out, done_out pulse, sticky overrun_out.
module vga_snapshot_manager #(
   parameter int DATA_WIDTH           = 16,
   parameter int MEMORY_ADDRESS_WIDTH = 11,
   parameter int AUX_ADDRESS_WIDTH    = 6,
   parameter int CPU_ELEMENTS         = 10,
   parameter int INSTR_WORDS          = 10,
   parameter int DATA_WORDS           = 10,
   parameter int READ_LATENCY         = 1
) (
   input  logic                            clock_in,
   input  logic                            reset_n_in,
   input  logic                            v_sync_in,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0] instr_base_in,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0] data_base_in,
   input  logic [DATA_WIDTH-1:0]           cpu_content_in,
   input  logic [DATA_WIDTH-1:0]           instruction_memory_in,
   input  logic [DATA_WIDTH-1:0]           data_memory_in,
   output logic [CPU_ELEMENTS-1:0]         content_enable_out,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] instruction_address_out,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] data_address_out,
   output logic                            aux_wr_out,
   output logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddress_out,
   output logic [DATA_WIDTH-1:0]           aux_data_out,
   output logic                            busy_out,
   output logic                            done_out,
   output logic                            overrun_out
);
   typedef enum logic [2:0] {IDLE, CPU, INSTR, DATA, DRAIN} state_t;
   localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_CPU   = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS - 1);
   localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_INSTR = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS + INSTR_WORDS - 1);
   localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_DATA  = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS + INSTR_WORDS + DATA_WORDS - 1);
   state_t                            state_q, state_d;
   logic                              vs_q, start, abort, fin, issue, empty;
   logic [AUX_ADDRESS_WIDTH-1:0]      idx_q;
   logic [MEMORY_ADDRESS_WIDTH-1:0]   ia_q, da_q;
   logic [READ_LATENCY-1:0]           pv_q, ps_q;
   logic [AUX_ADDRESS_WIDTH-1:0]      pa_q [READ_LATENCY];
   logic                              wr_q, done_q, ovr_q;
   logic [AUX_ADDRESS_WIDTH-1:0]      aa_q;
   logic [DATA_WIDTH-1:0]             ad_q;
   // idx_q is the aux address of the element handled this cycle; it runs across all three phases
   assign start = v_sync_in && !vs_q && state_q == IDLE;
   assign issue = state_q == INSTR || state_q == DATA;
   assign empty = pv_q == '0;
   // an empty pipeline in DRAIN means the final write is on the port now, so completion beats a falling v_sync
   assign fin   = state_q == DRAIN && empty;
   assign abort = state_q != IDLE && !v_sync_in && !fin;
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (abort) state_d = IDLE;
      else case (state_q)
         IDLE:    state_d = start ? CPU : IDLE;
         CPU:     state_d = idx_q == LAST_CPU ? INSTR : CPU;
         INSTR:   state_d = idx_q == LAST_INSTR ? DATA : INSTR;
         DATA:    state_d = idx_q == LAST_DATA ? DRAIN : DATA;
         DRAIN:   state_d = empty ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      content_enable_out = state_q == CPU ? CPU_ELEMENTS'(1) << idx_q : '0;
      busy_out           = state_q != IDLE;
   end
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         vs_q   <= 1'b0;
         idx_q  <= '0;
         ia_q   <= '0;
         da_q   <= '0;
         pv_q   <= '0;
         ps_q   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pa_q[i] <= '0;
         wr_q   <= 1'b0;
         aa_q   <= '0;
         ad_q   <= '0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         vs_q    <= v_sync_in;
         done_q  <= fin;
         wr_q    <= 1'b0;
         pv_q[0] <= issue;
         ps_q[0] <= state_q == DATA;
         pa_q[0] <= idx_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            ps_q[i] <= ps_q[i-1];
            pa_q[i] <= pa_q[i-1];
         end
         if (state_q inside {CPU, INSTR, DATA}) idx_q <= idx_q + 1'b1;
         if (state_q == INSTR && idx_q != LAST_INSTR) ia_q <= ia_q + 1'b1;
         if (state_q == DATA && idx_q != LAST_DATA) da_q <= da_q + 1'b1;
         if (state_q == CPU) begin
            wr_q <= 1'b1;
            aa_q <= idx_q;
            ad_q <= cpu_content_in;
         end
         if (pv_q[READ_LATENCY-1]) begin
            wr_q <= 1'b1;
            aa_q <= pa_q[READ_LATENCY-1];
            ad_q <= ps_q[READ_LATENCY-1] ? data_memory_in : instruction_memory_in;
         end
         if (start) begin
            idx_q <= '0;
            ia_q  <= instr_base_in;
            da_q  <= data_base_in;
            ovr_q <= 1'b0;
         end
         if (abort) begin
            wr_q  <= 1'b0;
            pv_q  <= '0;
            ovr_q <= 1'b1;
         end
      end
   end
   assign instruction_address_out = ia_q;
   assign data_address_out        = da_q;
   assign aux_wr_out              = wr_q;
   assign aux_waddress_out        = aa_q;
   assign aux_data_out            = ad_q;
   assign done_out                = done_q;
   assign overrun_out             = ovr_q;
endmodule
